// File: rtl/ascon_perm_ctrl_if.sv
// Request/control bundle between the mode FSM, the permutation sequencer and
// the round datapath. The master drives requests and the counter value; the slave is the sequencer.
interface ascon_perm_ctrl_if #(
   parameter int CPT_W = 4,
   parameter int NBP_W = 16
);
   logic             start_i;
   logic             mode_p12_i;
   logic             abort_i;
   logic [CPT_W-1:0] cpt_i;
   logic             ready_o;
   logic             busy_o;
   logic             en_cpt_o;
   logic             init_p12_o;
   logic             init_p8_o;
   logic             sel_state_o;
   logic             en_reg_o;
   logic             done_o;
   logic             error_o;
   logic [NBP_W-1:0] nb_perm_o;

   modport master (
      output start_i, mode_p12_i, abort_i, cpt_i,
      input  ready_o, busy_o, en_cpt_o, init_p12_o, init_p8_o,
             sel_state_o, en_reg_o, done_o, error_o, nb_perm_o
   );

   modport slave (
      input  start_i, mode_p12_i, abort_i, cpt_i,
      output ready_o, busy_o, en_cpt_o, init_p12_o, init_p8_o,
             sel_state_o, en_reg_o, done_o, error_o, nb_perm_o
   );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation sequencer: runs one p12 or p8 permutation per request by driving
// the round counter, the state-input mux and the state-register enable.
module ascon_perm_ctrl #(
   parameter int CPT_W      = 4,
   parameter int LAST_ROUND = 11,
   parameter int NBP_W      = 16
) (
   input  logic             clock_i,
   input  logic             resetb_i,
   ascon_perm_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CPT_W-1:0] LAST_CPT = CPT_W'(LAST_ROUND);
   localparam logic [NBP_W-1:0] NB_MAX   = {NBP_W{1'b1}};
   localparam logic [NBP_W-1:0] NB_ONE   = NBP_W'(1);

   state_t           state_r;
   state_t           state_next_s;
   logic             err_r;
   logic             err_set_s;
   logic             perm_inc_s;
   logic [NBP_W-1:0] nb_perm_r;

   logic             ready_s;
   logic             busy_s;
   logic             en_cpt_s;
   logic             init_p12_s;
   logic             init_p8_s;
   logic             sel_state_s;
   logic             en_reg_s;
   logic             done_s;

   // State register
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and control decode; the accept cycle is decoded combinationally so the
   // counter load happens on the same edge that leaves IDLE.
   always_comb begin
      state_next_s = state_r;
      ready_s      = 1'b0;
      busy_s       = 1'b0;
      en_cpt_s     = 1'b0;
      init_p12_s   = 1'b0;
      init_p8_s    = 1'b0;
      sel_state_s  = 1'b0;
      en_reg_s     = 1'b0;
      done_s       = 1'b0;
      err_set_s    = 1'b0;
      perm_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (bus.abort_i) begin
               state_next_s = ST_IDLE;
            end else if (bus.start_i) begin
               en_cpt_s     = 1'b1;
               init_p12_s   = bus.mode_p12_i;
               init_p8_s    = ~bus.mode_p12_i;
               state_next_s = ST_FIRST;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FIRST: begin
            busy_s = 1'b1;
            if (bus.abort_i) begin
               state_next_s = ST_IDLE;
            end else begin
               sel_state_s  = 1'b0;
               en_reg_s     = 1'b1;
               en_cpt_s     = 1'b1;
               state_next_s = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_s = 1'b1;
            if (bus.abort_i) begin
               state_next_s = ST_IDLE;
            end else if (bus.cpt_i > LAST_CPT) begin
               // Corrupted round index: drop the permutation rather than emit garbage
               err_set_s    = 1'b1;
               state_next_s = ST_IDLE;
            end else if (bus.cpt_i == LAST_CPT) begin
               sel_state_s  = 1'b1;
               en_reg_s     = 1'b1;
               state_next_s = ST_DONE;
            end else begin
               sel_state_s  = 1'b1;
               en_reg_s     = 1'b1;
               en_cpt_s     = 1'b1;
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.abort_i) begin
               state_next_s = ST_IDLE;
            end else begin
               done_s       = 1'b1;
               perm_inc_s   = 1'b1;
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Sticky range error, cleared only by reset
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Saturating count of completed permutations
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         nb_perm_r <= {NBP_W{1'b0}};
      end else if (perm_inc_s && (nb_perm_r != NB_MAX)) begin
         nb_perm_r <= nb_perm_r + NB_ONE;
      end else begin
         nb_perm_r <= nb_perm_r;
      end
   end

   assign bus.ready_o     = ready_s;
   assign bus.busy_o      = busy_s;
   assign bus.en_cpt_o    = en_cpt_s;
   assign bus.init_p12_o  = init_p12_s;
   assign bus.init_p8_o   = init_p8_s;
   assign bus.sel_state_o = sel_state_s;
   assign bus.en_reg_o    = en_reg_s;
   assign bus.done_o      = done_s;
   assign bus.error_o     = err_r;
   assign bus.nb_perm_o   = nb_perm_r;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed and randomized bench for ascon_perm_ctrl with a round-counter environment
// and a per-permutation schedule model.
module tb_ascon_perm_ctrl;

   localparam int CPT_W  = 4;
   localparam int NBP_W  = 4;
   localparam int LAST   = 11;
   localparam int NB_SAT = (1 << NBP_W) - 1;

   logic clock_i = 1'b0;
   logic resetb_i;

   always #5 clock_i = ~clock_i;

   ascon_perm_ctrl_if #(.CPT_W(CPT_W), .NBP_W(NBP_W)) bus ();

   ascon_perm_ctrl #(.CPT_W(CPT_W), .LAST_ROUND(LAST), .NBP_W(NBP_W)) dut (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;
   int nb_exp = 0;
   bit err_exp = 1'b0;

   logic [CPT_W-1:0] cnt = '0;
   bit               force_en = 1'b0;
   logic [CPT_W-1:0] force_val = '0;

   // Round counter as seen by the datapath: load 0/4 or increment when enabled
   always_ff @(posedge clock_i) begin
      if (bus.en_cpt_o) begin
         if (bus.init_p12_o)     cnt <= 4'd0;
         else if (bus.init_p8_o) cnt <= 4'd4;
         else                    cnt <= cnt + 4'd1;
      end
   end

   assign bus.cpt_i = force_en ? force_val : cnt;

   function automatic logic [5:0] ctrl_vec();
      return {bus.en_cpt_o, bus.init_p12_o, bus.init_p8_o,
              bus.sel_state_o, bus.en_reg_o, bus.done_o};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_nb"},  32'(bus.nb_perm_o), 32'(nb_exp));
      chk({tag, "_err"}, 32'(bus.error_o),   32'(err_exp));
   endtask

   // One idle cycle; never an accepting combination (start without abort)
   task automatic idle_cycle(input bit st, input bit md, input bit ab);
      @(negedge clock_i);
      bus.start_i = st & ab; bus.mode_p12_i = md; bus.abort_i = ab;
      #1;
      chk("idle_ready", 32'(bus.ready_o), 32'd1);
      chk("idle_ctrl",  32'(ctrl_vec()),  32'd0);
      chk_status("idle");
   endtask

   // One request: abort_k / err_k select the cycle (1 = FIRST) at which to abort or
   // corrupt the counter; 0 means never. hold keeps start_i high throughout.
   task automatic run_perm(input bit p12, input int abort_k, input int err_k, input bit hold);
      int rounds;
      int base;
      rounds = p12 ? 12 : 8;
      base   = p12 ? 0 : 4;
      @(negedge clock_i);
      bus.start_i = 1'b1; bus.mode_p12_i = p12; bus.abort_i = 1'b0;
      #1;
      chk("acc_ready", 32'(bus.ready_o), 32'd1);
      chk("acc_ctrl",  32'(ctrl_vec()),  32'({1'b1, p12, ~p12, 3'b000}));
      chk_status("acc");
      for (int k = 1; k <= rounds + 1; k++) begin
         @(negedge clock_i);
         bus.start_i    = hold ? 1'b1 : 1'($urandom_range(0, 1));
         bus.mode_p12_i = 1'($urandom_range(0, 1));
         bus.abort_i    = (k == abort_k);
         if (k == err_k) begin
            force_en  = 1'b1;
            force_val = 4'd13;
         end
         #1;
         if (k == abort_k || k == err_k) begin
            chk("drop_ctrl", 32'(ctrl_vec()), 32'd0);
            chk_status("drop");
            @(negedge clock_i);
            force_en = 1'b0;
            bus.abort_i = 1'b0;
            bus.start_i = 1'b0;
            if (k == err_k) err_exp = 1'b1;
            #1;
            chk("drop_ready", 32'(bus.ready_o), 32'd1);
            chk("drop_busy",  32'(bus.busy_o),  32'd0);
            chk_status("drop_next");
            return;
         end
         if (k <= rounds) begin
            chk("run_busy",  32'(bus.busy_o),  32'd1);
            chk("run_ready", 32'(bus.ready_o), 32'd0);
            chk("run_ctrl",  32'(ctrl_vec()),
                32'({(k < rounds), 2'b00, (k != 1), 1'b1, 1'b0}));
            chk("run_cpt",   32'(bus.cpt_i),   32'(base + k - 1));
         end else begin
            chk("done_ctrl",  32'(ctrl_vec()),  32'd1);
            chk("done_ready", 32'(bus.ready_o), 32'd0);
            chk("done_busy",  32'(bus.busy_o),  32'd0);
            chk_status("done");
            nb_exp = (nb_exp == NB_SAT) ? NB_SAT : nb_exp + 1;
         end
      end
   endtask

   initial begin
      int rounds;
      resetb_i = 1'b0;
      bus.start_i = 1'b0; bus.mode_p12_i = 1'b0; bus.abort_i = 1'b0;
      repeat (2) @(negedge clock_i);
      #1;
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_busy",  32'(bus.busy_o),  32'd0);
      chk("rst_ctrl",  32'(ctrl_vec()),  32'd0);
      chk_status("rst");
      @(negedge clock_i);
      resetb_i = 1'b1;

      idle_cycle(1'b0, 1'b1, 1'b0);
      run_perm(1'b1, 0, 0, 1'b0);
      idle_cycle(1'b0, 1'b0, 1'b0);
      run_perm(1'b0, 0, 0, 1'b0);
      idle_cycle(1'b0, 1'b0, 1'b0);

      // Back-to-back with start held high
      run_perm(1'b1, 0, 0, 1'b1);
      run_perm(1'b0, 0, 0, 1'b1);
      run_perm(1'b0, 0, 0, 1'b1);

      // Abort at the 5th round of p12, then p8 completes
      run_perm(1'b1, 5, 0, 1'b0);
      run_perm(1'b0, 0, 0, 1'b0);

      // Abort beats start in IDLE
      idle_cycle(1'b1, 1'b1, 1'b1);
      idle_cycle(1'b0, 1'b0, 1'b0);

      // Randomized traffic, enough completions to reach counter saturation
      for (int i = 0; i < 30; i++) begin
         bit md;
         bit ab;
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            ab = 1'($urandom_range(0, 1));
            idle_cycle(ab ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), ab);
         end
         md = 1'($urandom_range(0, 1));
         rounds = md ? 12 : 8;
         run_perm(md, ($urandom_range(0, 3) == 0) ? $urandom_range(1, rounds + 1) : 0,
                  0, 1'($urandom_range(0, 1)));
      end
      idle_cycle(1'b0, 1'b0, 1'b0);

      // Counter out of range during RUN, then error stays set across a normal perm
      run_perm(1'b1, 0, 4, 1'b0);
      run_perm(1'b0, 0, 0, 1'b0);
      idle_cycle(1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of RUN
      @(negedge clock_i);
      bus.start_i = 1'b1; bus.mode_p12_i = 1'b1;
      @(negedge clock_i);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clock_i);
      #1;
      chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
      #1;
      resetb_i = 1'b0;
      nb_exp = 0;
      err_exp = 1'b0;
      #1;
      chk("arst_ready", 32'(bus.ready_o), 32'd1);
      chk("arst_ctrl",  32'(ctrl_vec()),  32'd0);
      chk_status("arst");
      @(negedge clock_i);
      resetb_i = 1'b1;
      run_perm(1'b0, 0, 0, 1'b0);
      idle_cycle(1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
